// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the RV32I core: byte-banked synchronous RAM, aligned and
// extended loads with one-cycle latency, and a small MMIO window (LED and misalign status).
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [13:0] LED_ADDR    = 14'h2000,
  parameter logic [13:0] STATUS_ADDR = 14'h2004
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [13:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        memwrite_i,
  input  logic        memread_i,
  input  logic [2:0]  sign_mask_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  led_o,
  output logic        misalign_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {SrcZero, SrcRam, SrcMmio} src_e;

  logic [7:0]    r_mem [4][DEPTH_WORDS];
  logic [31:0]   r_rd_ram;
  logic [31:0]   r_rd_mmio;
  src_e          r_src;
  logic [1:0]    r_off;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [7:0]    r_led;
  logic          r_misalign;

  logic [AW-1:0] w_idx;
  logic [1:0]    w_size;
  logic          w_is_ram;
  logic          w_is_led;
  logic          w_is_status;
  logic          w_mis;
  logic          w_store;
  logic          w_load;
  logic          w_st_ram;
  logic [3:0]    w_be;
  logic [7:0]    w_lane [4];
  logic [31:0]   w_shift;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign w_idx       = addr_i[AW+1:2];
  assign w_size      = sign_mask_i[1:0];
  assign w_is_ram    = ~addr_i[13];
  assign w_is_led    = (addr_i == LED_ADDR);
  assign w_is_status = (addr_i == STATUS_ADDR);
  assign w_mis       = (w_size == 2'b01 && addr_i[0]) || (w_size[1] && addr_i[1:0] != 2'b00);
  // A simultaneous read+write strobe is a store only.
  assign w_store     = memwrite_i;
  assign w_load      = memread_i & ~memwrite_i;
  assign w_st_ram    = w_store & w_is_ram & ~w_mis;

  always_comb begin
    w_be = 4'b0000;
    if (w_size[1])           w_be = 4'b1111;
    else if (w_size == 2'b01) w_be = addr_i[1] ? 4'b1100 : 4'b0011;
    else                     w_be = 4'b0001 << addr_i[1:0];
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      w_lane[l] = wdata_i[7:0];
      if (w_size[1])            w_lane[l] = wdata_i[8*l +: 8];
      else if (w_size == 2'b01) w_lane[l] = wdata_i[8*(l%2) +: 8];
    end
  end

  // RAM banks: no reset; a store coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < 4; l++) begin
      if (w_st_ram && w_be[l] && rstn_i) r_mem[l][w_idx] <= w_lane[l];
      if (w_load && w_is_ram)            r_rd_ram[8*l +: 8] <= r_mem[l][w_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_src      <= SrcZero;
      r_rd_mmio  <= 32'd0;
      r_off      <= 2'b00;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
      r_led      <= 8'd0;
      r_misalign <= 1'b0;
    end else begin
      if (w_load) begin
        r_off     <= addr_i[1:0];
        r_size    <= w_size;
        r_uns     <= sign_mask_i[2];
        r_rd_mmio <= w_is_led ? {24'd0, r_led} : {31'd0, r_misalign};
        if (w_mis)                        r_src <= SrcZero;
        else if (w_is_ram)                r_src <= SrcRam;
        else if (w_is_led || w_is_status) r_src <= SrcMmio;
        else                              r_src <= SrcZero;
      end
      if (w_store && w_is_led && !w_mis) r_led <= wdata_i[7:0];
      if ((w_store || w_load) && w_mis)       r_misalign <= 1'b1;
      else if (w_store && w_is_status)        r_misalign <= 1'b0;
    end
  end

  assign w_shift = r_rd_ram >> {r_off, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = r_off[1] ? r_rd_ram[31:16] : r_rd_ram[15:0];

  always_comb begin
    rdata_o = 32'd0;
    unique case (r_src)
      SrcRam: begin
        if (r_size[1])            rdata_o = r_rd_ram;
        else if (r_size == 2'b01) rdata_o = {{16{w_half[15] & ~r_uns}}, w_half};
        else                      rdata_o = {{24{w_byte[7] & ~r_uns}}, w_byte};
      end
      SrcMmio: rdata_o = r_rd_mmio;
      default: rdata_o = 32'd0;
    endcase
  end

  assign led_o      = r_led;
  assign misalign_o = r_misalign;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with hand-computed expected values.
module tb_data_mem_ctrl;

  localparam logic [2:0] MB  = 3'b000;
  localparam logic [2:0] MBU = 3'b100;
  localparam logic [2:0] MH  = 3'b001;
  localparam logic [2:0] MHU = 3'b101;
  localparam logic [2:0] MW  = 3'b010;

  logic        clk;
  logic        rstn;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic        memwrite;
  logic        memread;
  logic [2:0]  sign_mask;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic        misalign;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_ctrl #(
    .DEPTH_WORDS (1024),
    .LED_ADDR    (14'h2000),
    .STATUS_ADDR (14'h2004)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .memwrite_i  (memwrite),
    .memread_i   (memread),
    .sign_mask_i (sign_mask),
    .rdata_o     (rdata),
    .led_o       (led),
    .misalign_o  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock of activity; outputs are sampled 1 time unit after the edge.
  task automatic op(input logic we, input logic re, input logic [13:0] a,
                    input logic [31:0] d, input logic [2:0] m);
    memwrite  = we;
    memread   = re;
    addr      = a;
    wdata     = d;
    sign_mask = m;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    memread  = 1'b0;
  endtask

  task automatic st(input logic [13:0] a, input logic [31:0] d, input logic [2:0] m);
    op(1'b1, 1'b0, a, d, m);
  endtask

  task automatic ld(input logic [13:0] a, input logic [2:0] m);
    op(1'b0, 1'b1, a, 32'd0, m);
  endtask

  initial begin
    rstn = 1'b0; memwrite = 1'b0; memread = 1'b0;
    addr = '0; wdata = '0; sign_mask = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {24'd0, led}, 32'h0);
    check("rst_mis", {31'd0, misalign}, 32'h0);

    // Store under reset must not land
    st(14'h0010, 32'h1111_1111, MW);
    rstn = 1'b0;
    st(14'h0010, 32'hDEAD_BEEF, MW);
    rstn = 1'b1;
    ld(14'h0010, MW);
    check("rst_abort", rdata, 32'h1111_1111);

    st(14'h0020, 32'h8081_7F80, MW);
    ld(14'h0020, MB);  check("lb",  rdata, 32'hFFFF_FF80);
    ld(14'h0021, MBU); check("lbu", rdata, 32'h0000_007F);
    ld(14'h0022, MH);  check("lh",  rdata, 32'hFFFF_8081);
    ld(14'h0022, MHU); check("lhu", rdata, 32'h0000_8081);
    ld(14'h0020, MW);  check("lw",  rdata, 32'h8081_7F80);
    ld(14'h0021, MB);  check("lb_pos", rdata, 32'h0000_007F);

    st(14'h0030, 32'h1122_3344, MW);
    st(14'h0031, 32'h1234_56AA, MB);
    ld(14'h0030, MW);  check("sb_lw", rdata, 32'h1122_AA44);
    st(14'h0032, 32'hFFFF_BEEF, MH);
    ld(14'h0030, MW);  check("sh_lw", rdata, 32'hBEEF_AA44);

    st(14'h2000, 32'h1234_56C3, MW);
    check("led_out", {24'd0, led}, 32'h0000_00C3);
    ld(14'h2000, MW);  check("led_ld", rdata, 32'h0000_00C3);
    op(1'b0, 1'b0, 14'h0000, 32'd0, MW);
    check("hold", rdata, 32'h0000_00C3);
    st(14'h3000, 32'hFFFF_FFFF, MW);
    check("hole_st_led", {24'd0, led}, 32'h0000_00C3);
    ld(14'h3000, MW);  check("hole_ld", rdata, 32'h0);

    st(14'h0040, 32'h5566_7788, MW);
    check("mis_clr0", {31'd0, misalign}, 32'h0);
    st(14'h0041, 32'hDEAD_BEEF, MW);
    check("mis_set", {31'd0, misalign}, 32'h1);
    ld(14'h0040, MW);  check("mis_noram", rdata, 32'h5566_7788);
    ld(14'h0043, MH);  check("mis_ld", rdata, 32'h0);
    ld(14'h2004, MW);  check("stat_ld1", rdata, 32'h1);
    st(14'h2004, 32'h0, MW);
    check("mis_clr", {31'd0, misalign}, 32'h0);
    ld(14'h2004, MW);  check("stat_ld0", rdata, 32'h0);

    ld(14'h0020, MW);
    op(1'b1, 1'b1, 14'h0050, 32'h5, MW);
    check("rw_hold", rdata, 32'h8081_7F80);
    ld(14'h0050, MW);  check("rw_store", rdata, 32'h5);

    st(14'h1000, 32'hCAFE_F00D, MW);
    ld(14'h0000, MW);  check("alias", rdata, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
